sobel_edge_stream: RTL and testbench

//  Streaming 3x3 Sobel edge detector for raster-order greyscale frames. Parametrised

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/sobel_line_buf.sv | 23 ++
 rtl/sobel_edge_stream.sv | 170 +++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector.
// Gradient widths are derived per instance from PIX_W using the helpers below.
package sobel_pkg;

  // Guard bits above PIX_W: |G| <= 4*PIX_MAX, plus the sign bit.
  localparam int GRAD_GUARD = 3;

  localparam int W_EDGE = 1;
  localparam int W_MID  = 2;

  typedef enum logic {
    MODE_MAG = 1'b0,
    MODE_BIN = 1'b1
  } out_mode_e;

  typedef struct packed {
    logic eol;
    logic eof;
  } frame_flags_t;

  function automatic int grad_w(input int pix_w);
    return pix_w + GRAD_GUARD;
  endfunction

  function automatic int pix_max(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: a single write port and an asynchronous read port on the same address.
// A read and a write in the same cycle return the old contents.
module sobel_line_buf #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: window -> gradients -> magnitude/threshold, 3-cycle latency.
// Backpressure: the whole pipeline stalls while the output holds an unaccepted pixel.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int PIX_W    = 8,
  parameter int BIN_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_eol,
  output logic             m_eof
);

  localparam int GRAD_W  = grad_w(PIX_W);
  localparam int PIX_MAX = pix_max(PIX_W);
  localparam int CW      = $clog2(IMG_W);
  localparam int RW      = $clog2(IMG_H);
  localparam out_mode_e MODE = (BIN_MODE != 0) ? MODE_BIN : MODE_MAG;
  localparam logic [PIX_W-1:0] PIX_ONES = '1;

  logic             run;
  logic             adv;
  logic             beat;
  logic [CW-1:0]    col;
  logic [CW-1:0]    eff_col;
  logic [RW-1:0]    row;
  logic [RW-1:0]    eff_row;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] win [3][3];

  logic                     v1;
  logic                     v2;
  frame_flags_t             f1;
  frame_flags_t             f2;
  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic [GRAD_W-1:0]        gx_abs;
  logic [GRAD_W-1:0]        gy_abs;
  logic [GRAD_W-1:0]        mag;
  logic [PIX_W-1:0]         out_pix;

  assign adv      = !m_valid || m_ready;
  assign s_ready  = adv && run;
  assign beat     = s_valid && s_ready;
  // A start-of-frame beat is pixel (0,0) whatever the counters say.
  assign eff_col  = s_sof ? '0 : col;
  assign eff_row  = s_sof ? '0 : row;
  assign last_col = (eff_col == CW'(IMG_W - 1));
  assign last_row = (eff_row == RW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      col <= '0;
      row <= '0;
    end else begin
      run <= 1'b1;
      if (beat) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
      end
    end
  end

  // LB0 holds row r-1, LB1 row r-2; LB1 is refilled from LB0's old contents.
  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (beat),
    .addr  (eff_col),
    .wdata (s_data),
    .rdata (lb0_q)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (beat),
    .addr  (eff_col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // win[row][col]: row 0 is the oldest line, col 2 the newest column.
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      f1 <= '0;
      v2 <= 1'b0;
      f2 <= '0;
    end else if (adv) begin
      v1     <= beat && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      f1.eol <= last_col;
      f1.eof <= last_col && last_row;
      v2     <= v1;
      f2     <= f1;
    end
  end

  function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return GRAD_W'(W_EDGE) * GRAD_W'(a) + GRAD_W'(W_MID) * GRAD_W'(b)
         + GRAD_W'(W_EDGE) * GRAD_W'(c);
  endfunction

  // Differences wrap modulo 2^GRAD_W, which is exact since |G| fits the signed range.
  always_ff @(posedge clk) begin
    if (adv) begin
      gx <= $signed(wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]));
      gy <= $signed(wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]));
    end
  end

  always_comb begin
    gx_abs  = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    gy_abs  = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag     = gx_abs + gy_abs;
    out_pix = '0;
    if (MODE == MODE_BIN) begin
      out_pix = (mag >= GRAD_W'(thresh)) ? PIX_ONES : '0;
    end else begin
      out_pix = (mag > GRAD_W'(PIX_MAX)) ? PIX_ONES : mag[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (adv) begin
      m_valid <= v2;
      m_data  <= out_pix;
      m_eol   <= v2 && f2.eol;
      m_eof   <= v2 && f2.eof;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Bench for sobel_edge_stream: magnitude and binary instances share one input stream,
// outputs are scored against a frame-level Sobel model.
module tb_sobel_edge_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          m_ready = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic [PW-1:0] thresh = '0;

  logic          s_ready0, m_valid0, m_eol0, m_eof0;
  logic          s_ready1, m_valid1, m_eol1, m_eof1;
  logic [PW-1:0] m_data0, m_data1;

  always #5 clk = ~clk;

  sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BIN_MODE(0)) dut_mag (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_sof(s_sof), .thresh(thresh), .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_eol(m_eol0), .m_eof(m_eof0)
  );

  sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BIN_MODE(1)) dut_bin (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_sof(s_sof), .thresh(thresh), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_eol(m_eol1), .m_eof(m_eof1)
  );

  typedef struct {
    int d0;
    int d1;
    bit eol;
    bit eof;
  } exp_t;

  typedef struct {
    int px;
    bit sof;
  } beat_t;

  exp_t  exp_q[$];
  beat_t in_q[$];
  int    img[H][W];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0 flat 50, 1 vertical step at col 4, 2 column ramp 10*c, 3 random
  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 50;
          1:       img[r][c] = (c >= 4) ? 100 : 0;
          2:       img[r][c] = 10 * c;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic queue_beats(input int n_beats);
    for (int k = 0; k < n_beats; k++) begin
      beat_t b;
      b.px  = img[k / W][k % W];
      b.sof = (k == 0);
      in_q.push_back(b);
    end
  endtask

  // The k-th beat of a frame sits at (k/W, k%W); once two rows and two columns are
  // behind it, it completes the window centred one row up and one column left.
  task automatic model_frame(input int n_beats, input int th);
    for (int k = 0; k < n_beats; k++) begin
      int r = k / W;
      int c = k % W;
      if (r >= 2 && c >= 2) begin
        int   gx = 0;
        int   gy = 0;
        int   mag;
        exp_t e;
        for (int i = -1; i <= 1; i++) begin
          int wt = (i == 0) ? 2 : 1;
          gx += wt * (img[r-1+i][c] - img[r-1+i][c-2]);
          gy += wt * (img[r][c-1+i] - img[r-2][c-1+i]);
        end
        mag   = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e.d0  = (mag > 255) ? 255 : mag;
        e.d1  = (mag >= th) ? 255 : 0;
        e.eol = (c == W - 1);
        e.eof = e.eol && (r == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input string tag, input int gap_pct, input int stall_pct,
                     input int stop_beats);
    int   budget = 4000;
    int   nacc = 0;
    int   nout = 0;
    int   neof = 0;
    int   exp_n = exp_q.size();
    int   exp_eof = 0;
    logic prev_hold = 1'b0;
    logic [PW-1:0] pd0 = '0, pd1 = '0;
    logic pe = 1'b0, pf = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].eof) exp_eof++;
    while ((in_q.size() > 0 || exp_q.size() > 0) && budget > 0 &&
           (stop_beats < 0 || nacc < stop_beats)) begin
      @(negedge clk);
      budget--;
      if (prev_hold) begin
        check({tag, "_hold_valid"}, m_valid0, 1);
        check({tag, "_hold_d0"}, m_data0, pd0);
        check({tag, "_hold_d1"}, m_data1, pd1);
        check({tag, "_hold_eol"}, m_eol0, pe);
        check({tag, "_hold_eof"}, m_eof0, pf);
      end
      m_ready = ($urandom_range(99) >= stall_pct);
      if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        s_valid = 1'b1;
        s_data  = PW'(in_q[0].px);
        s_sof   = in_q[0].sof;
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = PW'($urandom);
      end
      #1;
      if (s_valid && s_ready0) begin
        void'(in_q.pop_front());
        nacc++;
      end
      if (m_valid0 && m_ready) begin
        check({tag, "_pair_valid"}, m_valid1, 1);
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_out"}, 1, 0);
        end else begin
          exp_t e = exp_q.pop_front();
          check({tag, "_d0"}, m_data0, e.d0);
          check({tag, "_d1"}, m_data1, e.d1);
          check({tag, "_eol"}, m_eol0, e.eol);
          check({tag, "_eof"}, m_eof0, e.eof);
          check({tag, "_eol_bin"}, m_eol1, e.eol);
          check({tag, "_eof_bin"}, m_eof1, e.eof);
        end
        nout++;
        if (m_eof0) neof++;
      end
      prev_hold = m_valid0 && !m_ready;
      pd0 = m_data0;
      pd1 = m_data1;
      pe  = m_eol0;
      pf  = m_eof0;
    end
    check({tag, "_timeout"}, budget > 0, 1);
    if (stop_beats < 0) begin
      check({tag, "_count"}, nout, exp_n);
      check({tag, "_eof_count"}, neof, exp_eof);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        #1;
        check({tag, "_extra_out"}, m_valid0, 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid0, 0);
    check({tag, "_m_data"}, m_data0, 0);
    check({tag, "_m_eol"}, m_eol0, 0);
    check({tag, "_m_eof"}, m_eof0, 0);
    check({tag, "_m_valid_bin"}, m_valid1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_s_ready", s_ready0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_release_s_ready", s_ready0, 1);

    thresh = 8'd0;
    fill(0); queue_beats(W * H); model_frame(W * H, 0);
    run("flat", 0, 0, -1);

    fill(1); queue_beats(W * H); model_frame(W * H, 0);
    run("vstep", 0, 0, -1);

    thresh = 8'd80;
    fill(2); queue_beats(W * H); model_frame(W * H, 80);
    run("ramp_t80", 0, 0, -1);

    thresh = 8'd81;
    fill(2); queue_beats(W * H); model_frame(W * H, 81);
    run("ramp_t81", 0, 0, -1);

    thresh = 8'd100;
    fill(1); queue_beats(W * H); model_frame(W * H, 100);
    run("vstep_stall", 30, 40, -1);

    thresh = 8'($urandom_range(255));
    fill(3); queue_beats(W * H); model_frame(W * H, int'(thresh));
    run("random_stall", 25, 35, -1);

    // First frame abandoned mid row 3 by a new start-of-frame.
    thresh = 8'd60;
    fill(3); queue_beats(W * 3 + 3); model_frame(W * 3 + 3, 60);
    fill(3); queue_beats(W * H); model_frame(W * H, 60);
    run("sof_abort", 20, 30, -1);

    // Reset in the middle of row 4 while outputs are streaming.
    thresh = 8'd90;
    fill(3); queue_beats(W * H); model_frame(W * H, 90);
    run("pre_rst", 0, 0, W * 4 + 6);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    #1;
    check("pre_rst_valid", m_valid0, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    in_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_release_s_ready", s_ready0, 1);

    // Restart without s_sof: the first beat after reset is (0,0) anyway.
    fill(3); queue_beats(W * H); model_frame(W * H, 90);
    in_q[0].sof = 1'b0;
    run("post_rst", 10, 20, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
